// File: rtl/zb_fifo_pkg.sv
// Shared types, default sizes and the bit-select helper for the serial FIFO.
//   - shiftState_e   : shifter FSM states (S_EMPTY, S_SHIFT)
//   - ZB_FIFO_*      : default word width and depth
//   - selectBit()    : picks bit 'index' of a word in LSB-first or MSB-first order
// Optional feature macro used by zb_serial_fifo: ZB_FIFO_ERR_FLAGS_EN.
package zb_fifo_pkg;

    localparam int ZB_FIFO_IN_WIDTH = 4;
    localparam int ZB_FIFO_DEPTH    = 16;

    // Widest word selectBit() can handle; callers zero-extend their word to this.
    localparam int ZB_FIFO_MAX_W    = 64;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_SHIFT = 1'b1
    } shiftState_e;

    // index counts serialisation order: index 0 is the first bit sent.
    function automatic logic selectBit(
        input logic [ZB_FIFO_MAX_W-1:0] word,
        input int                       index,
        input int                       width,
        input logic                     msbFirst
    );
        int pos;
        pos = msbFirst ? (width - 1 - index) : index;
        return word[pos[5:0]];
    endfunction

endpackage

// File: rtl/zb_fifo_ram.sv
// Register-array storage for the serial FIFO: one synchronous write port and
// one combinational read port. Holds no pointer logic.
//   clock        : rising-edge clock
//   writeEnable  : store writeData at writeAddress on this edge
//   writeAddress : write location
//   writeData    : word to store
//   readAddress  : read location
//   readData     : word at readAddress (combinational)
module zb_fifo_ram
    import zb_fifo_pkg::*;
#(
    parameter  int WIDTH  = ZB_FIFO_IN_WIDTH,
    parameter  int DEPTH  = ZB_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] writeAddress,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [ADDR_W-1:0] readAddress,
    output logic [WIDTH-1:0]  readData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only ever read behind the
    // level counter, so stale words are never observed and no reset fan-out is needed.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    assign readData = mem[readAddress];

endmodule

// File: rtl/zb_serial_fifo.sv
// Word-in, bit-out FIFO for the Zigbee transmit chain. Buffers DEPTH words of
// IN_WIDTH bits and serialises them one bit per read request.
//   inClock       : clock, all logic on rising edge
//   inReset       : synchronous active-low reset
//   inData        : word to write
//   inWriteEnable : write request (one word per cycle)
//   inReadEnable  : read request (one bit per cycle)
//   outData       : registered serial bit, holds when outValid is low
//   outValid      : one-cycle strobe for a newly read bit
//   outEmpty      : no bit available (memory and shifter both empty)
//   outFull       : memory holds DEPTH words
//   outLevel      : words in memory, excluding the word in the shifter
// Optional macro ZB_FIFO_ERR_FLAGS_EN adds sticky outOverflow (write while
// full) and outUnderflow (read while empty), cleared only by reset.
module zb_serial_fifo
    import zb_fifo_pkg::*;
#(
    parameter  int IN_WIDTH  = ZB_FIFO_IN_WIDTH,
    parameter  int DEPTH     = ZB_FIFO_DEPTH,
    parameter  int MSB_FIRST = 0,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                inClock,
    input  logic                inReset,
    input  logic [IN_WIDTH-1:0] inData,
    input  logic                inWriteEnable,
    input  logic                inReadEnable,
    output logic                outData,
    output logic                outValid,
    output logic                outEmpty,
    output logic                outFull,
    output logic [LVL_W-1:0]    outLevel
`ifdef ZB_FIFO_ERR_FLAGS_EN
    ,
    output logic                outOverflow,
    output logic                outUnderflow
`endif
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam int                IDX_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IN_WIDTH - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic              MSB      = (MSB_FIRST != 0);

    logic [ADDR_W-1:0]   wrPtr;
    logic [ADDR_W-1:0]   rdPtr;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    levelNext;
    shiftState_e         state;
    logic [IN_WIDTH-1:0] shifter;
    logic [IDX_W-1:0]    bitIndex;
    logic [IN_WIDTH-1:0] headWord;
    logic                writeOk;
    logic                readOk;
    logic                pop;

    zb_fifo_ram #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock        (inClock),
        .writeEnable  (writeOk),
        .writeAddress (wrPtr),
        .writeData    (inData),
        .readAddress  (rdPtr),
        .readData     (headWord)
    );

    assign outEmpty = (level == '0) && (state == S_EMPTY);
    assign outFull  = (level == FULL_LVL);
    assign outLevel = level;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign writeOk = inWriteEnable && !outFull;
    assign readOk  = inReadEnable && !outEmpty;
    // Memory is only popped when a new word starts; bits of the current word
    // come from the shifter.
    assign pop     = readOk && (state == S_EMPTY);

    // NOTE: default assignment first so every path assigns levelNext and no
    // latch is inferred.
    always_comb begin
        levelNext = level;
        case ({writeOk, pop})
            2'b10:   levelNext = level + 1'b1;
            2'b01:   levelNext = level - 1'b1;
            default: levelNext = level;
        endcase
    end

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            state    <= S_EMPTY;
            shifter  <= '0;
            bitIndex <= '0;
            outData  <= 1'b0;
            outValid <= 1'b0;
        end else begin
            outValid <= 1'b0;
            level    <= levelNext;
            if (writeOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (readOk) begin
                outValid <= 1'b1;
                case (state)
                    S_EMPTY: begin
                        outData <= selectBit(ZB_FIFO_MAX_W'(headWord), 0, IN_WIDTH, MSB);
                        // Single-bit words are fully consumed on the pop itself.
                        if (IN_WIDTH > 1) begin
                            shifter  <= headWord;
                            bitIndex <= IDX_W'(1);
                            state    <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        outData <= selectBit(ZB_FIFO_MAX_W'(shifter), int'(bitIndex), IN_WIDTH, MSB);
                        // No prefetch: the next word is popped by the next valid read.
                        if (bitIndex == LAST_IDX) begin
                            bitIndex <= '0;
                            state    <= S_EMPTY;
                        end else begin
                            bitIndex <= bitIndex + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef ZB_FIFO_ERR_FLAGS_EN
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            outOverflow  <= 1'b0;
            outUnderflow <= 1'b0;
        end else begin
            if (inWriteEnable && outFull) begin
                outOverflow <= 1'b1;
            end
            if (inReadEnable && outEmpty) begin
                outUnderflow <= 1'b1;
            end
        end
    end
`else
    // Without the error flags, dropped writes and ignored reads are silent.
`endif

endmodule
